// File: rtl/memctrl_pkg.sv
// Shared types and constants for the data-memory controller.
// Provides default ADDR_W/DATA_W via MEMORY_DEPTH/MEMORY_WIDTH when not set by the build.
`ifndef MEMORY_DEPTH
`define MEMORY_DEPTH 32
`endif
`ifndef MEMORY_WIDTH
`define MEMORY_WIDTH 32
`endif

package memctrl_pkg;

  typedef enum logic [1:0] {
    W_BYTE = 2'b00,
    W_HALF = 2'b01,
    W_WORD = 2'b10
  } mem_width_e;

  localparam logic [3:0] OFF_TX_DATA  = 4'h0;
  localparam logic [3:0] OFF_STATUS   = 4'h4;
  localparam logic [3:0] OFF_MTIME_LO = 4'h8;
  localparam logic [3:0] OFF_MTIME_HI = 4'hC;

  localparam int unsigned ST_TX_FULL  = 0;
  localparam int unsigned ST_TX_EMPTY = 1;
  localparam int unsigned ST_MISALIGN = 2;
  localparam int unsigned ST_OVERFLOW = 3;

endpackage

// File: rtl/memctrl_tx_fifo.sv
// Console TX byte FIFO with registered valid/head/full/empty outputs.
// Accepts a push while full only if a pop happens in the same cycle.
module memctrl_tx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic [7:0] i_push_data,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_full,
  output logic       o_empty,
  output logic       o_push_acc_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_valid;
  logic [7:0]       r_data;
  logic             r_full;
  logic             r_empty;

  logic             w_pop;
  logic             w_push_acc;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [PTR_W-1:0] w_rd_nxt;
  logic [PTR_W-1:0] w_wr_nxt;
  logic [7:0]       w_head_nxt;

  // Next pointers/count; head bypasses the incoming byte when it becomes the head.
  always_comb begin
    w_pop      = r_valid & i_ready;
    w_push_acc = i_push & (~r_full | w_pop);
    w_cnt_nxt  = r_count + CNT_W'(w_push_acc) - CNT_W'(w_pop);
    w_rd_nxt   = r_rd_ptr + PTR_W'(w_pop);
    w_wr_nxt   = r_wr_ptr + PTR_W'(w_push_acc);
    w_head_nxt = 8'h00;
    if (w_cnt_nxt != '0) begin
      if (w_push_acc && (w_rd_nxt == r_wr_ptr)) w_head_nxt = i_push_data;
      else                                       w_head_nxt = r_mem[w_rd_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_data   <= 8'h00;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      r_rd_ptr <= w_rd_nxt;
      r_wr_ptr <= w_wr_nxt;
      r_count  <= w_cnt_nxt;
      r_valid  <= (w_cnt_nxt != '0);
      r_data   <= w_head_nxt;
      r_full   <= (w_cnt_nxt == CNT_W'(DEPTH));
      r_empty  <= (w_cnt_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_acc) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_valid      = r_valid;
  assign o_data       = r_data;
  assign o_full       = r_full;
  assign o_empty      = r_empty;
  assign o_push_acc_c = w_push_acc;

endmodule

// File: rtl/data_memory_controller.sv
// Data-memory responder: word RAM, mtime/status MMIO window and console TX FIFO.
module data_memory_controller
  import memctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W    = `MEMORY_DEPTH,
  parameter int unsigned       DATA_W    = `MEMORY_WIDTH,
  parameter int unsigned       RAM_WORDS = 4096,
  parameter logic [ADDR_W-1:0] MMIO_BASE = ADDR_W'(32'hFFFF_0000),
  parameter int unsigned       TX_DEPTH  = 4,
  parameter string             INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] memory_read_address,
  output logic [DATA_W-1:0] memory_read_data,
  input  logic [1:0]        memory_write_width,
  input  logic [ADDR_W-1:0] memory_write_address,
  input  logic [DATA_W-1:0] memory_write_data,
  input  logic              memory_write_enable,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              mem_error
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);

  logic [DATA_W-1:0] r_ram [RAM_WORDS];
  logic [63:0]       r_mtime;
  logic              r_misalign;
  logic              r_overflow;
  logic              r_mem_error;

  logic              w_rd_mmio;
  logic              w_wr_mmio;
  logic [RAM_AW-1:0] w_rd_idx;
  logic [RAM_AW-1:0] w_wr_idx;
  logic [DATA_W-1:0] w_ram_word;
  logic [DATA_W-1:0] w_status;
  mem_width_e        w_width;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wlanes;
  logic              w_bad;
  logic              w_tx_push;
  logic              w_st_wr;
  logic              w_lo_wr;
  logic              w_hi_wr;
  logic              w_push_acc;
  logic              w_full;
  logic              w_empty;
  logic              w_misalign_nxt;
  logic              w_overflow_nxt;

  assign w_rd_mmio  = (memory_read_address[ADDR_W-1:4] == MMIO_BASE[ADDR_W-1:4]);
  assign w_wr_mmio  = (memory_write_address[ADDR_W-1:4] == MMIO_BASE[ADDR_W-1:4]);
  assign w_rd_idx   = memory_read_address[RAM_AW+1:2];
  assign w_wr_idx   = memory_write_address[RAM_AW+1:2];
  assign w_ram_word = r_ram[w_rd_idx];
  assign w_width    = mem_width_e'(memory_write_width);

  // Combinational read path: RAM word shifted down by the byte offset, or an MMIO register.
  always_comb begin
    w_status              = '0;
    w_status[ST_TX_FULL]  = w_full;
    w_status[ST_TX_EMPTY] = w_empty;
    w_status[ST_MISALIGN] = r_misalign;
    w_status[ST_OVERFLOW] = r_overflow;
    memory_read_data      = '0;
    if (w_rd_mmio) begin
      case ({memory_read_address[3:2], 2'b00})
        OFF_STATUS:   memory_read_data = w_status;
        OFF_MTIME_LO: memory_read_data = r_mtime[31:0];
        OFF_MTIME_HI: memory_read_data = r_mtime[63:32];
        default:      memory_read_data = '0;
      endcase
    end else begin
      memory_read_data = w_ram_word >> {memory_read_address[1:0], 3'b000};
    end
  end

  // Write decode: RAM byte enables, MMIO strobes, and alignment faults.
  always_comb begin
    w_be      = 4'b0000;
    w_wlanes  = '0;
    w_bad     = 1'b0;
    w_tx_push = 1'b0;
    w_st_wr   = 1'b0;
    w_lo_wr   = 1'b0;
    w_hi_wr   = 1'b0;
    if (memory_write_enable) begin
      if (w_wr_mmio) begin
        if ((w_width == W_WORD) && (memory_write_address[1:0] == 2'b00)) begin
          case (memory_write_address[3:0])
            OFF_TX_DATA:  w_tx_push = 1'b1;
            OFF_STATUS:   w_st_wr   = 1'b1;
            OFF_MTIME_LO: w_lo_wr   = 1'b1;
            OFF_MTIME_HI: w_hi_wr   = 1'b1;
            default:      w_bad     = 1'b1;
          endcase
        end else begin
          w_bad = 1'b1;
        end
      end else begin
        case (w_width)
          W_BYTE: begin
            w_be     = 4'b0001 << memory_write_address[1:0];
            w_wlanes = {4{memory_write_data[7:0]}};
          end
          W_HALF: begin
            if (memory_write_address[0]) w_bad = 1'b1;
            else w_be = memory_write_address[1] ? 4'b1100 : 4'b0011;
            w_wlanes = {2{memory_write_data[15:0]}};
          end
          W_WORD: begin
            if (memory_write_address[1:0] != 2'b00) w_bad = 1'b1;
            else w_be = 4'b1111;
            w_wlanes = memory_write_data;
          end
          default: w_bad = 1'b1;
        endcase
      end
    end
  end

  // Sticky flags: a set in the same cycle as a write-1-to-clear wins.
  always_comb begin
    w_misalign_nxt = w_bad | (r_misalign & ~(w_st_wr & memory_write_data[ST_MISALIGN]));
    w_overflow_nxt = (w_tx_push & ~w_push_acc) |
                     (r_overflow & ~(w_st_wr & memory_write_data[ST_OVERFLOW]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtime     <= 64'd0;
      r_misalign  <= 1'b0;
      r_overflow  <= 1'b0;
      r_mem_error <= 1'b0;
    end else begin
      r_misalign  <= w_misalign_nxt;
      r_overflow  <= w_overflow_nxt;
      r_mem_error <= w_misalign_nxt | w_overflow_nxt;
      if (w_lo_wr)      r_mtime <= {r_mtime[63:32], memory_write_data};
      else if (w_hi_wr) r_mtime <= {memory_write_data, r_mtime[31:0]};
      else              r_mtime <= r_mtime + 64'd1;
    end
  end

  // RAM is never reset; lanes commit independently.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_be[b]) r_ram[w_wr_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
    end
  end

  logic w_unused_init;
  assign w_unused_init = (INIT_FILE == "");

  memctrl_tx_fifo #(
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_tx_push),
    .i_push_data  (memory_write_data[7:0]),
    .i_ready      (tx_ready),
    .o_valid      (tx_valid),
    .o_data       (tx_data),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_push_acc_c (w_push_acc)
  );

  assign mem_error = r_mem_error;

endmodule
